// File: rtl/rssb_pkg.sv
// Shared types and default constants for the RSSB one-instruction processor.
package rssb_pkg;

  localparam int unsigned RSSB_WIDTH = 8;
  localparam int unsigned RSSB_RET_W = 16;

  localparam logic [RSSB_WIDTH-1:0] RSSB_START_PC  = 8'h00;
  localparam logic [RSSB_WIDTH-1:0] RSSB_HALT_ADDR = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } rssb_state_t;

endpackage

// File: rtl/rssb_alu.sv
// Reverse-subtract datapath: diff = m - a (wrapping), borrow from a signed compare.
module rssb_alu
  import rssb_pkg::*;
#(
  parameter int unsigned WIDTH = RSSB_WIDTH
) (
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  always_comb begin
    diff   = m - a;
    borrow = ($signed(m) < $signed(a));
  end

endmodule

// File: rtl/rssb_ctrl.sv
// RSSB control unit: sole bus initiator, sequences FETCH/EXEC from start until a halt operand.
module rssb_ctrl
  import rssb_pkg::*;
#(
  parameter int unsigned     WIDTH     = RSSB_WIDTH,
  parameter logic [WIDTH-1:0] START_PC  = WIDTH'(RSSB_START_PC),
  parameter logic [WIDTH-1:0] HALT_ADDR = WIDTH'(RSSB_HALT_ADDR)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [WIDTH-1:0]        mem_address,
  output logic                    mem_write,
  output logic [WIDTH-1:0]        mem_wdata,
  input  logic signed [WIDTH-1:0] mem_rdata,
  output logic                    busy,
  output logic                    halted,
  output logic [WIDTH-1:0]        pc,
  output logic signed [WIDTH-1:0] acc,
  output logic [RSSB_RET_W-1:0]   retired
);

  rssb_state_t            state, state_next;
  logic [WIDTH-1:0]       ir, ir_next;
  logic [WIDTH-1:0]       pc_next;
  logic [WIDTH-1:0]       acc_next;
  logic [RSSB_RET_W-1:0]  retired_next;
  logic [WIDTH-1:0]       diff;
  logic                   borrow;

  rssb_alu #(.WIDTH(WIDTH)) u_alu (
    .m      (mem_rdata),
    .a      (acc),
    .diff   (diff),
    .borrow (borrow)
  );

  // State and architectural registers; reset wins over everything at the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      pc      <= START_PC;
      acc     <= '0;
      ir      <= '0;
      retired <= '0;
      busy    <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      acc     <= acc_next;
      ir      <= ir_next;
      retired <= retired_next;
      busy    <= (state_next == FETCH) || (state_next == EXEC);
      halted  <= (state_next == HALTED);
    end
  end

  // Next-state and bus drive; bus depends only on registered state and read data.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    acc_next     = acc;
    ir_next      = ir;
    retired_next = retired;
    mem_address  = pc;
    mem_write    = 1'b0;
    mem_wdata    = '0;

    case (state)
      IDLE, HALTED: begin
        if (start) begin
          pc_next      = START_PC;
          acc_next     = '0;
          retired_next = '0;
          state_next   = FETCH;
        end
      end
      FETCH: begin
        ir_next = mem_rdata;
        if (mem_rdata == HALT_ADDR) begin
          state_next = HALTED;
        end else begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        mem_address  = ir;
        mem_write    = 1'b1;
        mem_wdata    = diff;
        acc_next     = diff;
        pc_next      = pc + (borrow ? WIDTH'(2) : WIDTH'(1));
        retired_next = (retired == '1) ? retired : retired + RSSB_RET_W'(1);
        state_next   = FETCH;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rssb_ctrl.sv
// Directed bench for rssb_ctrl: two instances (START_PC 0x00 and 0xFE) each with a byte memory model.
module tb_rssb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start_w;
  logic [7:0]  mem_address, mem_wdata, mem_rdata, pc, acc;
  logic        mem_write, busy, halted;
  logic [15:0] retired;
  logic [7:0]  mem_address_w, mem_wdata_w, mem_rdata_w, pc_w, acc_w;
  logic        mem_write_w, busy_w, halted_w;
  logic [15:0] retired_w;

  logic [7:0]  mem  [256];
  logic [7:0]  memw [256];
  logic        ld_en, ld_w, clr;
  logic [7:0]  ld_addr, ld_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rssb_ctrl #(.WIDTH(8), .START_PC(8'h00), .HALT_ADDR(8'hFF)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_address(mem_address), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .halted(halted),
    .pc(pc), .acc(acc), .retired(retired)
  );

  rssb_ctrl #(.WIDTH(8), .START_PC(8'hFE), .HALT_ADDR(8'hFF)) dut_w (
    .clk(clk), .rst(rst), .start(start_w),
    .mem_address(mem_address_w), .mem_write(mem_write_w), .mem_wdata(mem_wdata_w),
    .mem_rdata(mem_rdata_w), .busy(busy_w), .halted(halted_w),
    .pc(pc_w), .acc(acc_w), .retired(retired_w)
  );

  assign mem_rdata   = mem[mem_address];
  assign mem_rdata_w = memw[mem_address_w];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_write) begin
      mem[mem_address] <= mem_wdata;
    end else if (ld_en && !ld_w) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) memw[i] <= 8'h00;
    end else if (mem_write_w) begin
      memw[mem_address_w] <= mem_wdata_w;
    end else if (ld_en && ld_w) begin
      memw[ld_addr] <= ld_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr();
    tick();
    tick();
  endtask

  task automatic poke(input logic w, input logic [7:0] a, input logic [7:0] d);
    ld_w = w; ld_addr = a; ld_data = d; ld_en = 1'b1;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic wipe();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic load_basic();
    wipe();
    poke(1'b0, 8'h00, 8'h80); poke(1'b0, 8'h01, 8'h82); poke(1'b0, 8'h02, 8'h80);
    poke(1'b0, 8'h03, 8'hFF); poke(1'b0, 8'h04, 8'hFF);
    poke(1'b0, 8'h80, 8'h01); poke(1'b0, 8'h81, 8'h02);
    poke(1'b0, 8'h82, 8'h08); poke(1'b0, 8'h83, 8'h04);
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic go_w();
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; start_w = 1'b0;
    ld_en = 1'b0; ld_w = 1'b0; clr = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
    tick(); tick();

    // Reset state
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_acc", 32'(acc), 32'h00);
    chk("rst_retired", 32'(retired), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'h00);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h00);
    chk("rst_w_pc", 32'(pc_w), 32'hFE);
    chk("rst_w_mem_address", 32'(mem_address_w), 32'hFE);
    rst = 1'b1;

    // Basic program, cycle by cycle
    load_basic();
    go();
    chk("b_fetch_busy", 32'(busy), 32'd1);
    chk("b_fetch_addr", 32'(mem_address), 32'h00);
    chk("b_fetch_write", 32'(mem_write), 32'd0);
    tick();
    chk("b_exec_write", 32'(mem_write), 32'd1);
    chk("b_exec_addr", 32'(mem_address), 32'h80);
    chk("b_exec_wdata", 32'(mem_wdata), 32'h01);
    tick();
    chk("b_i1_acc", 32'(acc), 32'h01);
    chk("b_i1_pc", 32'(pc), 32'h01);
    chk("b_i1_m80", 32'(mem[8'h80]), 32'h01);
    chk("b_i1_retired", 32'(retired), 32'd1);
    instr();
    chk("b_i2_acc", 32'(acc), 32'h07);
    chk("b_i2_pc", 32'(pc), 32'h02);
    chk("b_i2_m82", 32'(mem[8'h82]), 32'h07);
    instr();
    chk("b_i3_acc", 32'(acc), 32'hFA);
    chk("b_i3_pc", 32'(pc), 32'h04);
    chk("b_i3_m80", 32'(mem[8'h80]), 32'hFA);
    chk("b_haltfetch_halted", 32'(halted), 32'd0);
    tick();
    chk("b_halted", 32'(halted), 32'd1);
    chk("b_halt_busy", 32'(busy), 32'd0);
    chk("b_halt_pc", 32'(pc), 32'h04);
    chk("b_halt_retired", 32'(retired), 32'd3);
    chk("b_halt_write", 32'(mem_write), 32'd0);

    // Restart from HALTED with modified data: M80=FA, M82=07
    go();
    chk("rs_pc", 32'(pc), 32'h00);
    chk("rs_acc", 32'(acc), 32'h00);
    chk("rs_retired", 32'(retired), 32'd0);
    chk("rs_busy", 32'(busy), 32'd1);
    wait_halt(20);
    chk("rs_pc_end", 32'(pc), 32'h03);
    chk("rs_acc_end", 32'(acc), 32'h00);
    chk("rs_retired_end", 32'(retired), 32'd2);
    chk("rs_m80", 32'(mem[8'h80]), 32'h00);

    // Reset sampled at the edge that would enter EXEC of instruction 2
    load_basic();
    go();
    instr();
    chk("r_fetch2_addr", 32'(mem_address), 32'h01);
    rst = 1'b0;
    tick();
    chk("r_write", 32'(mem_write), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_pc", 32'(pc), 32'h00);
    chk("r_acc", 32'(acc), 32'h00);
    chk("r_retired", 32'(retired), 32'd0);
    chk("r_addr", 32'(mem_address), 32'h00);
    chk("r_wdata", 32'(mem_wdata), 32'h00);
    tick();
    chk("r_m82", 32'(mem[8'h82]), 32'h08);
    chk("r_write2", 32'(mem_write), 32'd0);
    chk("r_halted", 32'(halted), 32'd0);
    rst = 1'b1;

    // start pulsed during EXEC of instruction 2 is ignored
    load_basic();
    go();
    instr();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sb_pc", 32'(pc), 32'h02);
    chk("sb_acc", 32'(acc), 32'h07);
    wait_halt(20);
    chk("sb_pc_end", 32'(pc), 32'h04);
    chk("sb_acc_end", 32'(acc), 32'hFA);
    chk("sb_retired", 32'(retired), 32'd3);

    // Self-modifying code
    wipe();
    poke(1'b0, 8'h00, 8'h00); poke(1'b0, 8'h01, 8'h81); poke(1'b0, 8'h02, 8'h02);
    poke(1'b0, 8'h04, 8'hFF); poke(1'b0, 8'h81, 8'h03);
    go();
    instr();
    chk("sm_i1_pc", 32'(pc), 32'h01);
    chk("sm_i1_acc", 32'(acc), 32'h00);
    chk("sm_i1_m0", 32'(mem[8'h00]), 32'h00);
    wait_halt(20);
    chk("sm_pc", 32'(pc), 32'h04);
    chk("sm_acc", 32'(acc), 32'hFF);
    chk("sm_m2", 32'(mem[8'h02]), 32'hFF);
    chk("sm_retired", 32'(retired), 32'd3);
    go();
    wait_halt(20);
    chk("sm2_pc", 32'(pc), 32'h02);
    chk("sm2_acc", 32'(acc), 32'h03);
    chk("sm2_retired", 32'(retired), 32'd2);

    // Signed borrow corners
    wipe();
    poke(1'b0, 8'h00, 8'h84); poke(1'b0, 8'h01, 8'h85); poke(1'b0, 8'h03, 8'h86);
    poke(1'b0, 8'h05, 8'h87); poke(1'b0, 8'h06, 8'hFF);
    poke(1'b0, 8'h84, 8'h01); poke(1'b0, 8'h85, 8'h80);
    poke(1'b0, 8'h86, 8'hFF); poke(1'b0, 8'h87, 8'h01);
    go();
    instr();
    chk("sg_i1_acc", 32'(acc), 32'h01);
    tick();
    chk("sg_i2_wdata", 32'(mem_wdata), 32'h7F);
    tick();
    chk("sg_i2_acc", 32'(acc), 32'h7F);
    chk("sg_i2_pc", 32'(pc), 32'h03);
    instr();
    chk("sg_i3_acc", 32'(acc), 32'h80);
    chk("sg_i3_pc", 32'(pc), 32'h05);
    instr();
    chk("sg_i4_acc", 32'(acc), 32'h81);
    chk("sg_i4_pc", 32'(pc), 32'h06);
    wait_halt(10);
    chk("sg_retired", 32'(retired), 32'd4);

    // PC wrap: skip at 0xFE lands on 0x00
    wipe();
    poke(1'b1, 8'hFE, 8'h80); poke(1'b1, 8'h80, 8'h80); poke(1'b1, 8'h00, 8'hFF);
    go_w();
    chk("w1_start_pc", 32'(pc_w), 32'hFE);
    instr();
    chk("w1_pc", 32'(pc_w), 32'h00);
    chk("w1_acc", 32'(acc_w), 32'h80);
    tick();
    chk("w1_halted", 32'(halted_w), 32'd1);
    chk("w1_retired", 32'(retired_w), 32'd1);

    // PC wrap: step to 0xFF, then skip from 0xFF lands on 0x01
    wipe();
    poke(1'b1, 8'hFE, 8'h81); poke(1'b1, 8'h81, 8'h05); poke(1'b1, 8'hFF, 8'h82);
    poke(1'b1, 8'h82, 8'h80); poke(1'b1, 8'h01, 8'hFF);
    go_w();
    instr();
    chk("w2_pc", 32'(pc_w), 32'hFF);
    chk("w2_acc", 32'(acc_w), 32'h05);
    instr();
    chk("w3_pc", 32'(pc_w), 32'h01);
    chk("w3_acc", 32'(acc_w), 32'h7B);
    chk("w3_m82", 32'(memw[8'h82]), 32'h7B);
    tick();
    chk("w3_halted", 32'(halted_w), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
